// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: drives PC to a combinational instruction ROM,
// latches and decodes the word, issues it, and counts retirements.
module instr_fetch_seq #(
  parameter int          PC_WIDTH    = 8,
  parameter int          INSTR_WIDTH = 16,
  parameter logic [7:0]  RESET_PC    = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  input  logic                   stall,
  input  logic                   exec_done,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [2:0]             rd,
  output logic [7:0]             imm8,
  output logic                   is_mem,
  output logic                   is_store,
  output logic                   is_ori,
  output logic                   is_jump,
  output logic                   is_nop,
  output logic [15:0]            retired_cnt
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;
  localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);

  logic [0:0] state;
  logic       retire;

  // Field decode straight off the latched instruction register
  always_comb begin
    rd       = instr[10:8];
    imm8     = instr[7:0];
    is_mem   = (instr[15:12] == 4'b1010);
    is_store = is_mem & instr[11];
    is_ori   = (instr[15:11] == 5'b00101);
    is_jump  = (instr[15:12] == 4'b1001);
    is_nop   = (instr == '0);
  end

  // Issue handshake; a NOP retires without waiting on the datapath
  always_comb begin
    instr_valid = (state == ISSUE);
    retire      = instr_valid & (exec_done | is_nop);
  end

  // Sequencer state, PC, instruction latch and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= PC_RST;
      instr       <= '0;
      retired_cnt <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (!stall) begin
            instr <= rom_data;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (retire) begin
            pc          <= is_jump ? jump_target : pc + PC_ONE;
            retired_cnt <= retired_cnt + 16'd1;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with a behavioural ROM
// and hand-computed expected values.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic [15:0] rom_data;
  logic        stall;
  logic        exec_done;
  logic [7:0]  jump_target;
  logic [15:0] instr;
  logic        instr_valid;
  logic [2:0]  rd;
  logic [7:0]  imm8;
  logic        is_mem;
  logic        is_store;
  logic        is_ori;
  logic        is_jump;
  logic        is_nop;
  logic [15:0] retired_cnt;

  logic [15:0] rom [256];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[pc];

  instr_fetch_seq dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .rom_data    (rom_data),
    .stall       (stall),
    .exec_done   (exec_done),
    .jump_target (jump_target),
    .instr       (instr),
    .instr_valid (instr_valid),
    .rd          (rd),
    .imm8        (imm8),
    .is_mem      (is_mem),
    .is_store    (is_store),
    .is_ori      (is_ori),
    .is_jump     (is_jump),
    .is_nop      (is_nop),
    .retired_cnt (retired_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1234;
    rom[8'h00] = 16'hA009;
    rom[8'h02] = 16'h9000;
    rom[8'h08] = 16'h2802;
    rom[8'h09] = 16'h9AE7;
    rom[8'h10] = 16'hA800;
    rom[8'h11] = 16'h9000;

    rst = 1'b1;
    stall = 1'b0;
    exec_done = 1'b1;
    jump_target = 8'h10;
    tick();
    tick();
    check("rst_pc", pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_nop", is_nop, 1);
    check("rst_mem", is_mem, 0);
    rst = 1'b0;

    // sequential run with exec_done tied high
    tick();
    check("t1_valid", instr_valid, 1);
    check("t1_pc0", pc, 0);
    check("t1_mem", is_mem, 1);
    check("t1_store", is_store, 0);
    check("t1_rd", rd, 0);
    check("t1_imm", imm8, 9);
    tick();
    check("t1_pc1", pc, 1);
    check("t1_fetch_valid", instr_valid, 0);
    tick();
    tick();
    check("t1_pc2", pc, 2);
    check("t1_cnt", retired_cnt, 2);

    // jump from 2 to 0x10
    tick();
    check("jmp_flag", is_jump, 1);
    tick();
    check("jmp_pc", pc, 8'h10);
    check("jmp_cnt", retired_cnt, 3);

    // store held in ISSUE for 5 cycles
    exec_done = 1'b0;
    tick();
    check("t2_store", is_store, 1);
    check("t2_rd", rd, 0);
    check("t2_imm", imm8, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hold_valid", instr_valid, 1);
      check("t2_hold_pc", pc, 8'h10);
    end
    exec_done = 1'b1;
    tick();
    check("t2_ret_pc", pc, 8'h11);
    check("t2_ret_cnt", retired_cnt, 4);

    // jump 0x11 -> 8, ORI, then 9AE7 jump to 0
    jump_target = 8'h08;
    tick();
    tick();
    check("t3_pc8", pc, 8'h08);
    tick();
    check("t3_ori", is_ori, 1);
    check("t3_ori_mem", is_mem, 0);
    check("t3_rd", rd, 0);
    check("t3_imm", imm8, 2);
    tick();
    check("t3_pc9", pc, 8'h09);
    jump_target = 8'h00;
    tick();
    check("t3_jmp", is_jump, 1);
    check("t3_jrd", rd, 2);
    check("t3_jimm", imm8, 8'hE7);
    tick();
    check("t3_pc0", pc, 0);
    check("t3_cnt", retired_cnt, 7);

    // wrap from 0xFF
    rom[8'h00] = 16'h9000;
    jump_target = 8'hFF;
    tick();
    tick();
    check("t4_pcff", pc, 8'hFF);
    tick();
    tick();
    check("t4_wrap", pc, 0);
    check("t4_cnt", retired_cnt, 9);

    // NOP retires without exec_done
    rom[8'h00] = 16'h0000;
    exec_done = 1'b0;
    tick();
    check("t5_nop", is_nop, 1);
    check("t5_valid", instr_valid, 1);
    tick();
    check("t5_pc", pc, 1);
    check("t5_cnt", retired_cnt, 10);
    check("t5_fetch", instr_valid, 0);

    // stall in FETCH, exec_done ignored there
    stall = 1'b1;
    exec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_stall_pc", pc, 1);
      check("t6_stall_instr", instr, 0);
      check("t6_stall_valid", instr_valid, 0);
    end
    check("t6_stall_cnt", retired_cnt, 10);
    stall = 1'b0;
    exec_done = 1'b0;
    tick();
    check("t6_issue", instr_valid, 1);
    check("t6_instr", instr, 16'h1234);

    // reset mid-ISSUE
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_pc", pc, 0);
    check("t6_rst_valid", instr_valid, 0);
    check("t6_rst_cnt", retired_cnt, 0);
    check("t6_rst_instr", instr, 0);
    tick();
    rst = 1'b0;
    exec_done = 1'b1;
    tick();
    check("post_rst_pc", pc, 0);
    check("post_rst_valid", instr_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
